// File: rtl/operand_fetch_pkg.sv
// Shared widths, control-bundle layout and ID/EX bundle for operand fetch.
// Also holds the operand resolve helper (x0 force + writeback bypass).
package operand_fetch_pkg;
  localparam int XLEN    = 32;
  localparam int MXLEN   = XLEN;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int CTRL_W  = 16;

  localparam int CTRL_ALU_LSB = 0;
  localparam int CTRL_ALU_W   = 5;
  localparam int CTRL_SRC_LSB = 5;
  localparam int CTRL_SRC_W   = 2;
  localparam int CTRL_MEM_LSB = 7;
  localparam int CTRL_MEM_W   = 4;
  localparam int CTRL_BR_LSB  = 11;
  localparam int CTRL_BR_W    = 5;

  typedef struct packed {
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              writes_rd;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  // The register file neither hardwires x0 nor forwards its write port.
  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_AW-1:0] rs,
    input logic              hit,
    input logic [REG_AW-1:0] wrd,
    input logic [XLEN-1:0]   wdata,
    input logic [XLEN-1:0]   rfv
  );
    if (rs == '0)
      return '0;
    else if (hit && (wrd == rs))
      return wdata;
    else
      return rfv;
  endfunction
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback or flush kill.
// Ports: set/clr/kill index pairs, three queries returning busy-after-clear.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_idx,
  input  logic [REG_AW-1:0] q0_idx,
  input  logic [REG_AW-1:0] q1_idx,
  input  logic [REG_AW-1:0] q2_idx,
  output logic              q0_busy,
  output logic              q1_busy,
  output logic              q2_busy
);
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_d;

  // Set applied last: a same-cycle clear belongs to the older producer.
  always_comb begin
    busy_d = busy;
    if (clr_en)
      busy_d[clr_idx] = 1'b0;
    if (kill_en)
      busy_d[kill_idx] = 1'b0;
    if (set_en)
      busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_d;
  end

  assign q0_busy = busy[q0_idx] && !(clr_en && clr_idx == q0_idx);
  assign q1_busy = busy[q1_idx] && !(clr_en && clr_idx == q1_idx);
  assign q2_busy = busy[q2_idx] && !(clr_en && clr_idx == q2_idx);
endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: RF read, bypass, hazard stall, ID/EX reg.
// Ports: in_* decoded instr, rf_* RF read, wb_* writeback snoop, out_* ID/EX.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic              in_writes_rd,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_read1,
  output logic [REG_AW-1:0] rf_read2,
  input  logic [XLEN-1:0]   rf_out1,
  input  logic [XLEN-1:0]   rf_out2,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_writes_rd,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl
);
  logic   wb_hit;
  logic   rs1_busy, rs2_busy, rd_busy;
  logic   raw1, raw2, waw, hazard;
  logic   accept, vld_q;
  logic   set_en, kill_en;
  id_ex_t ex_d, ex_q;

  assign wb_hit   = wb_regwrite && (wb_rd != '0);
  assign rf_read1 = in_rs1;
  assign rf_read2 = in_rs2;

  assign set_en  = accept && in_writes_rd && (in_rd != '0);
  assign kill_en = flush && vld_q && ex_q.writes_rd
                   && (ex_q.rd != '0);

  reg_scoreboard u_sb (
    .CLK      (CLK),
    .reset    (reset),
    .set_en   (set_en),
    .set_idx  (in_rd),
    .clr_en   (wb_hit),
    .clr_idx  (wb_rd),
    .kill_en  (kill_en),
    .kill_idx (ex_q.rd),
    .q0_idx   (in_rs1),
    .q1_idx   (in_rs2),
    .q2_idx   (in_rd),
    .q0_busy  (rs1_busy),
    .q1_busy  (rs2_busy),
    .q2_busy  (rd_busy)
  );

  // Query results already exclude registers written back this cycle.
  assign raw1   = in_uses_rs1 && (in_rs1 != '0) && rs1_busy;
  assign raw2   = in_uses_rs2 && (in_rs2 != '0) && rs2_busy;
  assign waw    = in_writes_rd && (in_rd != '0) && rd_busy;
  assign hazard = raw1 || raw2 || waw;

  assign in_ready = !flush && !hazard && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    ex_d.rs1_val   = resolve(in_rs1, wb_hit, wb_rd, wb_data, rf_out1);
    ex_d.rs2_val   = resolve(in_rs2, wb_hit, wb_rd, wb_data, rf_out2);
    ex_d.pc        = in_pc;
    ex_d.rd        = in_rd;
    ex_d.writes_rd = in_writes_rd;
    ex_d.ctrl      = in_ctrl;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      ex_q  <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      ex_q  <= ex_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid     = vld_q;
  assign out_rs1_val   = ex_q.rs1_val;
  assign out_rs2_val   = ex_q.rs2_val;
  assign out_rd        = ex_q.rd;
  assign out_writes_rd = ex_q.writes_rd;
  assign out_pc        = ex_q.pc;
  assign out_ctrl      = ex_q.ctrl;
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a
// randomized run against a queue-of-outstanding-producers model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic              CLK = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
  logic              in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [XLEN-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [REG_AW-1:0] rf_read1, rf_read2;
  logic [XLEN-1:0]   rf_out1, rf_out2;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_val, out_rs2_val;
  logic [REG_AW-1:0] out_rd;
  logic              out_writes_rd;
  logic [XLEN-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;

  logic [XLEN-1:0] rf [REG_NUM];
  assign rf_out1 = rf[rf_read1];
  assign rf_out2 = rf[rf_read2];

  int n_checks = 0;
  int n_fail = 0;

  // Model: list of registers with an outstanding producer + held instr.
  logic [REG_AW-1:0] pend_q[$];
  logic              m_v;
  logic [XLEN-1:0]   m_rs1, m_rs2, m_pc;
  logic [REG_AW-1:0] m_rd;
  logic              m_wr;
  logic [CTRL_W-1:0] m_ctrl;

  always #5 CLK = ~CLK;

  operand_fetch dut (
    .CLK           (CLK),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .in_uses_rs1   (in_uses_rs1),
    .in_uses_rs2   (in_uses_rs2),
    .in_writes_rd  (in_writes_rd),
    .in_pc         (in_pc),
    .in_ctrl       (in_ctrl),
    .rf_read1      (rf_read1),
    .rf_read2      (rf_read2),
    .rf_out1       (rf_out1),
    .rf_out2       (rf_out2),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1_val   (out_rs1_val),
    .out_rs2_val   (out_rs2_val),
    .out_rd        (out_rd),
    .out_writes_rd (out_writes_rd),
    .out_pc        (out_pc),
    .out_ctrl      (out_ctrl)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Edge, then commit the writeback to the bench register file.
  task automatic clk1();
    @(posedge CLK);
    #1;
    if (wb_regwrite) rf[wb_rd] = wb_data;
  endtask

  task automatic idle();
    in_valid = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
    in_writes_rd = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_pc = 0; in_ctrl = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rs1, rs2, rd,
                       input logic u1, u2, wr,
                       input logic [XLEN-1:0] pc,
                       input logic [CTRL_W-1:0] ctrl);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = wr;
    in_pc = pc; in_ctrl = ctrl;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    for (int i = 0; i < REG_NUM; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    clk1(); clk1();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    n_checks++; if (out_pc !== '0 || out_ctrl !== '0 || out_rd !== '0) begin n_fail++; $display("FAIL reset_fields pc=%0h ctrl=%0h rd=%0h exp=0", out_pc, out_ctrl, out_rd); end
    n_checks++; if (out_rs1_val !== '0 || out_rs2_val !== '0 || out_writes_rd !== 1'b0) begin n_fail++; $display("FAIL reset_ops got=%0h/%0h/%0h exp=0", out_rs1_val, out_rs2_val, out_writes_rd); end
    n_checks++; if (dut.u_sb.busy !== '0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", dut.u_sb.busy); end
    reset = 0;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_x0();
    rf[2] = 32'h0000_0022;
    issue(0, 2, 0, 1, 1, 1, 32'h100, 16'hA5A5);
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%0h exp=1", in_ready); end
    clk1();
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL x0_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs1_val !== '0) begin n_fail++; $display("FAIL x0_rs1 got=%0h exp=0", out_rs1_val); end
    n_checks++; if (out_rs2_val !== 32'h22) begin n_fail++; $display("FAIL x0_rs2 got=%0h exp=22", out_rs2_val); end
    n_checks++; if (out_pc !== 32'h100 || out_ctrl !== 16'hA5A5) begin n_fail++; $display("FAIL x0_pass pc=%0h ctrl=%0h exp=100/a5a5", out_pc, out_ctrl); end
    n_checks++; if (dut.u_sb.busy !== '0) begin n_fail++; $display("FAIL x0_busy got=%0h exp=0", dut.u_sb.busy); end
    clk1();
  endtask

  task automatic test_bypass();
    issue(0, 0, 3, 0, 0, 1, 32'h180, 16'h0003);
    clk1();
    idle();
    n_checks++; if (dut.u_sb.busy[3] !== 1'b1) begin n_fail++; $display("FAIL byp_busy_set got=%0h exp=1", dut.u_sb.busy[3]); end
    rf[3] = 32'hBAD0_0003;
    issue(3, 0, 0, 1, 0, 0, 32'h184, 16'h0004);
    wb_regwrite = 1; wb_rd = 3; wb_data = 32'h1234;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready got=%0h exp=1", in_ready); end
    clk1();
    idle();
    n_checks++; if (out_rs1_val !== 32'h1234) begin n_fail++; $display("FAIL byp_val got=%0h exp=1234", out_rs1_val); end
    n_checks++; if (dut.u_sb.busy[3] !== 1'b0) begin n_fail++; $display("FAIL byp_busy_clr got=%0h exp=0", dut.u_sb.busy[3]); end
    clk1();
  endtask

  task automatic test_raw_stall();
    issue(0, 0, 7, 0, 0, 1, 32'h1F0, 16'h0007);
    clk1();
    issue(0, 7, 0, 0, 1, 0, 32'h200, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      #3;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d got=%0h exp=0", i, in_ready); end
      clk1();
    end
    wb_regwrite = 1; wb_rd = 7; wb_data = 32'h55;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got=%0h exp=1", in_ready); end
    clk1();
    idle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin n_fail++; $display("FAIL raw_issue v=%0h pc=%0h exp=1/200", out_valid, out_pc); end
    n_checks++; if (out_rs2_val !== 32'h55) begin n_fail++; $display("FAIL raw_val got=%0h exp=55", out_rs2_val); end
    clk1();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    issue(0, 0, 0, 0, 0, 0, 32'h300, 16'h0300);
    clk1();
    issue(1, 1, 0, 1, 1, 0, 32'h304, 16'h0304);
    for (int i = 0; i < 4; i++) begin
      #3;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got=%0h exp=0", i, in_ready); end
      clk1();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin n_fail++; $display("FAIL bp_hold%0d v=%0h pc=%0h exp=1/300", i, out_valid, out_pc); end
    end
    out_ready = 1;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume got=%0h exp=1", in_ready); end
    clk1();
    idle();
    n_checks++; if (out_pc !== 32'h304 || out_ctrl !== 16'h0304) begin n_fail++; $display("FAIL bp_next pc=%0h ctrl=%0h exp=304", out_pc, out_ctrl); end
    clk1();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    issue(0, 0, 9, 0, 0, 1, 32'h400, 16'h0400);
    clk1();
    in_valid = 0;
    n_checks++; if (dut.u_sb.busy[9] !== 1'b1) begin n_fail++; $display("FAIL fl_busy_set got=%0h exp=1", dut.u_sb.busy[9]); end
    flush = 1;
    issue(1, 0, 0, 1, 0, 0, 32'h404, 16'h0404);
    #3;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got=%0h exp=0", in_ready); end
    clk1();
    idle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%0h exp=0", out_valid); end
    n_checks++; if (dut.u_sb.busy[9] !== 1'b0) begin n_fail++; $display("FAIL fl_busy_clr got=%0h exp=0", dut.u_sb.busy[9]); end
    rf[9] = 32'h99;
    issue(9, 0, 0, 1, 0, 0, 32'h408, 16'h0408);
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_reader got=%0h exp=1", in_ready); end
    clk1();
    idle();
    n_checks++; if (out_rs1_val !== 32'h99) begin n_fail++; $display("FAIL fl_val got=%0h exp=99", out_rs1_val); end
    clk1();
  endtask

  task automatic test_reset_midhold();
    out_ready = 0;
    issue(0, 0, 5, 0, 0, 1, 32'h500, 16'h0500);
    clk1();
    in_valid = 0;
    n_checks++; if (dut.u_sb.busy[5] !== 1'b1) begin n_fail++; $display("FAIL rm_busy_set got=%0h exp=1", dut.u_sb.busy[5]); end
    #2;
    reset = 1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got=%0h exp=0", out_valid); end
    n_checks++; if (dut.u_sb.busy !== '0 || out_pc !== '0) begin n_fail++; $display("FAIL rm_clear busy=%0h pc=%0h exp=0", dut.u_sb.busy, out_pc); end
    #1;
    reset = 0;
    idle();
    clk1();
  endtask

  function automatic bit in_pend(input logic [REG_AW-1:0] r);
    foreach (pend_q[i]) if (pend_q[i] == r) return 1;
    return 0;
  endfunction

  task automatic pend_remove(input logic [REG_AW-1:0] r);
    for (int i = pend_q.size() - 1; i >= 0; i--)
      if (pend_q[i] == r) pend_q.delete(i);
  endtask

  task automatic test_random(input int n);
    bit              hit, stall, exp_rdy, acc;
    logic [REG_NUM-1:0] bv;
    pend_q.delete();
    m_v = 0;
    for (int c = 0; c < n; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_rs1       = REG_AW'($urandom_range(0, 7));
      in_rs2       = REG_AW'($urandom_range(0, 7));
      in_rd        = REG_AW'($urandom_range(0, 7));
      in_uses_rs1  = ($urandom_range(0, 3) != 0);
      in_uses_rs2  = ($urandom_range(0, 1) != 0);
      in_writes_rd = ($urandom_range(0, 2) != 0);
      in_pc        = $urandom;
      in_ctrl      = CTRL_W'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      wb_regwrite  = ($urandom_range(0, 1) != 0);
      if (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
        wb_rd = pend_q[$urandom_range(0, pend_q.size() - 1)];
      else
        wb_rd = REG_AW'($urandom_range(0, 7));
      wb_data = $urandom;
      #3;
      hit = wb_regwrite && wb_rd != 0;
      stall = 0;
      if (in_uses_rs1 && in_rs1 != 0 && in_pend(in_rs1) && !(hit && wb_rd == in_rs1)) stall = 1;
      if (in_uses_rs2 && in_rs2 != 0 && in_pend(in_rs2) && !(hit && wb_rd == in_rs2)) stall = 1;
      if (in_writes_rd && in_rd != 0 && in_pend(in_rd) && !(hit && wb_rd == in_rd)) stall = 1;
      exp_rdy = !flush && !stall && (!m_v || out_ready);
      acc = in_valid && exp_rdy;
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, in_ready, exp_rdy); end
      if (hit) pend_remove(wb_rd);
      if (flush) begin
        if (m_v && m_wr && m_rd != 0) pend_remove(m_rd);
        m_v = 0;
      end else if (acc) begin
        m_v = 1;
        m_rs1 = (in_rs1 == 0) ? '0 : (hit && wb_rd == in_rs1) ? wb_data : rf[in_rs1];
        m_rs2 = (in_rs2 == 0) ? '0 : (hit && wb_rd == in_rs2) ? wb_data : rf[in_rs2];
        m_rd = in_rd; m_wr = in_writes_rd; m_pc = in_pc; m_ctrl = in_ctrl;
        if (in_writes_rd && in_rd != 0) pend_q.push_back(in_rd);
      end else if (out_ready) begin
        m_v = 0;
      end
      clk1();
      n_checks++; if (out_valid !== m_v) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, out_valid, m_v); end
      if (m_v) begin
        n_checks++;
        if (out_rs1_val !== m_rs1 || out_rs2_val !== m_rs2 || out_pc !== m_pc
            || out_ctrl !== m_ctrl || out_rd !== m_rd || out_writes_rd !== m_wr) begin
          n_fail++;
          $display("FAIL rnd_data c=%0d got=%0h/%0h/%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h/%0h/%0h", c,
                   out_rs1_val, out_rs2_val, out_pc, out_ctrl, out_rd, out_writes_rd,
                   m_rs1, m_rs2, m_pc, m_ctrl, m_rd, m_wr);
        end
      end
      bv = '0;
      foreach (pend_q[i]) bv[pend_q[i]] = 1'b1;
      n_checks++; if (dut.u_sb.busy !== bv) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", c, dut.u_sb.busy, bv); end
    end
    idle();
    clk1();
  endtask

  initial begin
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    test_reset();
    test_x0();
    test_bypass();
    test_raw_stall();
    test_backpressure();
    test_flush();
    test_reset_midhold();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute operand stage wrapped around the register file.
- Drives the register file read addresses and captures the two read values into an ID/EX pipeline register.
- Bypasses same-cycle writeback data and forces x0 to zero, because the register file does not hardwire x0 and does not forward writes to reads.
- Keeps a per-register busy scoreboard and stalls RAW/WAW hazards until the producing writeback occurs.

Parameters:
- XLEN, 32, operand/data width (matches MXLEN)
- REG_NUM, 32, number of architectural registers
- REG_AW, 5, register index width
- CTRL_W, 16, width of opaque decoded-control bundle passed through

Ports:
- CLK  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs1, in_rs2, in_rd  in  REG_AW each  register indices
- in_uses_rs1, in_uses_rs2, in_writes_rd  in  1 each  operand/destination enables
- in_pc  in  XLEN  instruction address
- in_ctrl  in  CTRL_W  decoded control, passed through unmodified
- rf_read1, rf_read2  out  REG_AW each  register file read addresses (combinational = in_rs1/in_rs2)
- rf_out1, rf_out2  in  XLEN each  register file read data
- wb_regwrite, wb_rd, wb_data  in  1/REG_AW/XLEN  snoop of the same writeback bus that drives the register file write port
- flush  in  1  kill the instruction held in the output register
- out_valid  out  1  held instruction valid
- out_ready  in  1  execute stage consumes the held instruction
- out_rs1_val, out_rs2_val  out  XLEN each  resolved operands
- out_rd, out_writes_rd, out_pc, out_ctrl  out  matching widths  registered copies

Behaviour:
- Reset (async): out_valid=0; all busy bits=0; out_rs1_val, out_rs2_val, out_pc, out_ctrl, out_rd, out_writes_rd=0.
- Writeback qualification: wb_hit = wb_regwrite && wb_rd!=0. A write to x0 is ignored for both bypass and scoreboard.
- Operand resolve, per source, rs selecting between rf_out1 and rf_out2 accordingly:
  - rs==0 -> 0.
  - else if wb_hit && wb_rd==rs -> wb_data.
  - else -> rf_out.
- RAW hazard on rsN: in_uses_rsN && rsN!=0 && busy[rsN] && !(wb_hit && wb_rd==rsN).
- WAW hazard: in_writes_rd && in_rd!=0 && busy[in_rd] && !(wb_hit && wb_rd==in_rd).
- in_ready = !flush && !hazard && (!out_valid || out_ready). Combinational; it may depend on in_* and wb_*.
- Accept = in_valid && in_ready. On the next edge the output register loads the resolved operands and pass-through fields, and out_valid=1. Latency is one cycle from accept to out_valid.
- If out_ready && out_valid && !accept, then out_valid goes to 0 on the next edge. Output fields are held while out_valid && !out_ready, with no glitching.
- Scoreboard:
  - Set busy[in_rd] on accept when in_writes_rd && in_rd!=0.
  - Clear busy[wb_rd] on wb_hit.
  - Set and clear of the same index in the same cycle: set wins. The clear belongs to the older producer; WAW stalling guarantees at most one outstanding producer per register.
- Flush (priority over everything except reset):
  - Next edge: out_valid=0.
  - If out_valid && out_writes_rd && out_rd!=0, clear busy[out_rd], unless the same cycle's wb_hit targets it, in which case it is cleared anyway.
  - No accept occurs in a flush cycle.
- busy[0] is constant 0.
- Reset asserted mid-stall or while an instruction is held drops everything. There is no replay.

Decomposition:
- Shared package/defs: XLEN/MXLEN, REG_NUM, REG_AW, CTRL_W, and the ctrl bundle field offsets.
- One sub-module: reg_scoreboard. It holds the REG_NUM-bit busy vector with set/clear ports and a query for up to three indices, returning busy-after-same-cycle-clear.
- Operand mux and output register stay in operand_fetch.

Test Plan:
- Reset mid-hold: held instruction rd=5, assert reset asynchronously -> out_valid=0 and busy[5]=0 immediately, with no clock edge needed.
- x0 handling: rf_out1=0xDEAD_BEEF, in_rs1=0, in_uses_rs1=1; accept -> out_rs1_val=0. Also in_writes_rd=1, in_rd=0 -> busy unchanged.
- Same-cycle bypass: busy[3]=1, in_rs1=3, wb_regwrite=1, wb_rd=3, wb_data=0x1234 -> in_ready=1. Next cycle out_rs1_val=0x1234 and busy[3]=0.
- RAW/WAW stall: accept rd=7, then present rs2=7 with no writeback -> in_ready=0 for 3 cycles. Writeback wb_rd=7, wb_data=0x55 in cycle 4 -> accept in that cycle, out_rs2_val=0x55.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs stable. Raise out_ready -> next instruction loads on the following edge.
- Flush: held instruction rd=9 (busy[9]=1), assert flush -> out_valid=0 and busy[9]=0 next cycle. A subsequent reader of x9 issues without stall, taking its value from rf_out.
